aes_round_engine: RTL and testbench
===================================

Name: aes_round_engine

Overview:
- Iterative AES block cipher core. One round per clock, runtime-selectable encrypt or decrypt, with valid/ready handshakes on input and output.
- Parametrised successor to the fixed AES-128 decryption pipeline. It is generalised to AES-128/192/256 through the round count.
- Sits between the block-level data mover and the key expansion unit. Takes a precomputed key schedule in the same packed word-array format as the existing decryption path.

Parameters:
NR  10  number of rounds; legal values 10, 12, 14 (AES-128/192/256); any other value is a compile-time error
NKW  4*(NR+1)  derived, not overridable; number of 32-bit words in the key schedule

Ports:
clk  input  1  system clock, rising edge active
n_rst  input  1  asynchronous active-low reset
flush  input  1  synchronous abort; discards the in-flight block
mode  input  1  1 = encrypt, 0 = decrypt; sampled only at input handshake
in_valid  input  1  d_in and mode are valid
in_ready  output  1  engine can accept a block this cycle
d_in  input  128  input block; [127:120] = byte 0, column-major per FIPS-197
key_schedule  input  [0:NKW-1][31:0]  expanded key; word 0 = first 32 key bits; must stay stable from accept until output handshake
out_valid  output  1  d_out holds a finished block
out_ready  input  1  downstream accepts d_out
d_out  output  128  result block, same byte order as d_in
busy  output  1  high in ROUND and DONE

Behaviour:
- Reset (n_rst low, asynchronous) drives all outputs low:
  - in_ready=0, out_valid=0, d_out=0, busy=0.
  - State register, round counter and mode latch are cleared.
  - FSM goes to IDLE.
  - in_ready rises to 1 from the first clock edge after n_rst deasserts.
- FSM states: IDLE, ROUND, DONE.
- in_ready = 1 in IDLE, and in DONE while out_ready=1. It is 0 otherwise.
- Accept occurs when in_valid and in_ready are both high at a rising edge. At accept:
  - mode is latched.
  - round counter is set to 1.
  - FSM goes to ROUND.
  - state loads the initial AddRoundKey: encrypt uses d_in ^ words 0..3; decrypt uses d_in ^ words 4NR..4NR+3.
- ROUND, one round per clock for r = 1..NR:
  - Encrypt: SubBytes, ShiftRows, MixColumns, then XOR with words 4r..4r+3. MixColumns is skipped when r = NR.
  - Decrypt (straight inverse cipher): InvShiftRows, InvSubBytes, XOR with words 4(NR-r)..4(NR-r)+3, then InvMixColumns. InvMixColumns is skipped when r = NR.
  - When r = NR: the result is written to d_out, out_valid is set, and FSM goes to DONE.
- Latency: out_valid is high from the NR-th rising edge after the accept edge. Throughput is one block per NR+1 cycles when out_ready is held high.
- DONE:
  - d_out and out_valid are held stable while out_ready=0.
  - On out_ready=1 without a new accept: out_valid clears and FSM goes to IDLE.
  - On out_ready=1 with a simultaneous accept: the output handshake completes and the new block is loaded. FSM goes to ROUND; out_valid is 0 on the next cycle.
- in_valid while in ROUND is ignored, because in_ready=0. The upstream must hold the data.
- flush=1 at a rising edge, from any state:
  - FSM goes to IDLE and out_valid goes to 0. d_out retains its last value.
  - No accept takes place on that edge, even if in_valid is high.
  - flush has priority over all other events.
- n_rst asserted mid-operation: the block is lost with no output, and all outputs read as at reset.
- Round counter width is ceil(log2(NR+1)) bits. It never wraps, because it is reloaded at each accept.
- GF(2^8) arithmetic uses the reduction polynomial x^8+x^4+x^3+x+1.
- S-box and inverse S-box are combinational byte lookups, 16 instances each, shared across rounds.

Test Plan:
- NR=10, encrypt: key schedule expanded from key 000102030405060708090a0b0c0d0e0f, d_in 00112233445566778899aabbccddeeff -> d_out 69c4e0d86a7b0430d8cdb78070b4c55a with out_valid exactly 10 edges after accept.
- NR=10, decrypt: same key, d_in 69c4e0d86a7b0430d8cdb78070b4c55a -> d_out 00112233445566778899aabbccddeeff.
- NR=12 and NR=14 builds, encrypt of plaintext 00112233445566778899aabbccddeeff:
  - 192-bit key 000102…17 -> dda97ca4864cdfe06eaf70a0ec0d7191, latency 12.
  - 256-bit key 000102…1f -> 8ea2b7ca516745bfeafc49904b496089, latency 14.
  - Decrypt of each ciphertext returns the plaintext.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid -> d_out stable and in_ready=0 throughout. Then raise out_ready and in_valid together, with mode flipped -> the new block is accepted the same edge, and the next result appears NR edges later.
- Back-to-back stream: 4 blocks, with in_valid and out_ready always high, alternating mode per block -> each result correct, and a result every NR+1 cycles.
- Abort: flush mid-ROUND at r=5, then n_rst pulse mid-ROUND on a second block -> no out_valid for either block, and outputs are at reset values. A following block completes correctly.

Source files
------------

// File: rtl/aes_round_engine.sv
// Iterative AES core: one round per clock, encrypt or decrypt per block, for AES-128/192/256
// selected by NR. Uses a precomputed key schedule and valid/ready handshakes on both sides.
module aes_round_engine #(
  parameter int NR = 10
) (
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic                  flush,
  input  logic                  mode,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [127:0]          d_in,
  input  logic [0:4*NR+3][31:0] key_schedule,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [127:0]          d_out,
  output logic                  busy
);

  localparam int NKW = 4 * (NR + 1);
  localparam int RW  = $clog2(NR + 1);
  localparam int KW  = $clog2(NKW);

  if (NR != 10 && NR != 12 && NR != 14) begin : g_bad_nr
    $error("aes_round_engine: NR must be 10, 12 or 14");
  end

  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  localparam logic [0:255][7:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  typedef enum logic [1:0] {IDLE, ROUND, DONE} fsm_t;

  // GF(2^8) doubling modulo x^8+x^4+x^3+x+1
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Returns {14*a, 11*a, 13*a, 9*a}
  function automatic logic [31:0] inv_mul(input logic [7:0] a);
    logic [7:0] x2, x4, x8;
    x2 = xtime(a);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return {x8 ^ x4 ^ x2, x8 ^ x2 ^ a, x8 ^ x4 ^ a, x8 ^ a};
  endfunction

  function automatic logic [31:0] mix_col(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = c;
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
    logic [31:0] p0, p1, p2, p3;
    p0 = inv_mul(c[31:24]);
    p1 = inv_mul(c[23:16]);
    p2 = inv_mul(c[15:8]);
    p3 = inv_mul(c[7:0]);
    return {p0[31:24] ^ p1[23:16] ^ p2[15:8]  ^ p3[7:0],
            p0[7:0]   ^ p1[31:24] ^ p2[23:16] ^ p3[15:8],
            p0[15:8]  ^ p1[7:0]   ^ p2[31:24] ^ p3[23:16],
            p0[23:16] ^ p1[15:8]  ^ p2[7:0]   ^ p3[31:24]};
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] o;
    for (int c = 0; c < 4; c++) o[127-32*c -: 32] = mix_col(s[127-32*c -: 32]);
    return o;
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] o;
    for (int c = 0; c < 4; c++) o[127-32*c -: 32] = inv_mix_col(s[127-32*c -: 32]);
    return o;
  endfunction

  // Byte k of the block sits at bits [127-8k -: 8]; row = k%4, column = k/4
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] o;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c+r)%4)) -: 8];
    return o;
  endfunction

  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c-r+4)%4)) -: 8];
    return o;
  endfunction

  function automatic logic [127:0] sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = SBOX[s[127-8*i -: 8]];
    return o;
  endfunction

  function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = INV_SBOX[s[127-8*i -: 8]];
    return o;
  endfunction

  function automatic logic [127:0] round_key(input logic [0:4*NR+3][31:0] ks,
                                             input logic [RW-1:0] k);
    logic [KW-1:0] b;
    b = KW'(k) << 2;
    return {ks[b], ks[b | KW'(1)], ks[b | KW'(2)], ks[b | KW'(3)]};
  endfunction

  fsm_t           fsm_q, fsm_d;
  logic [127:0]   state_q, state_d;
  logic [RW-1:0]  rnd_q, rnd_d;
  logic           mode_q, mode_d;
  logic [127:0]   d_out_d;
  logic           out_valid_d;
  logic           started_q;
  logic           accept;
  logic           last_round;
  logic [RW-1:0]  rk_sel;
  logic [127:0]   init_rk, round_rk, enc_sr, enc_out, dec_x, dec_out, round_out;

  // started_q keeps in_ready low until the first edge after reset release
  assign in_ready = started_q & ((fsm_q == IDLE) | ((fsm_q == DONE) & out_ready));
  assign accept   = in_valid & in_ready & ~flush;
  assign busy     = (fsm_q == ROUND) | (fsm_q == DONE);

  // Decrypt walks the schedule backwards from the final round key
  always_comb begin
    last_round = (rnd_q == RW'(NR));
    rk_sel     = mode_q ? rnd_q : RW'(NR) - rnd_q;
    round_rk   = round_key(key_schedule, rk_sel);
    init_rk    = round_key(key_schedule, mode ? '0 : RW'(NR));
    enc_sr     = shift_rows(sub_bytes(state_q));
    enc_out    = (last_round ? enc_sr : mix_columns(enc_sr)) ^ round_rk;
    dec_x      = inv_shift_rows(inv_sub_bytes(state_q)) ^ round_rk;
    dec_out    = last_round ? dec_x : inv_mix_columns(dec_x);
    round_out  = mode_q ? enc_out : dec_out;
  end

  always_comb begin
    fsm_d       = fsm_q;
    state_d     = state_q;
    rnd_d       = rnd_q;
    mode_d      = mode_q;
    d_out_d     = d_out;
    out_valid_d = out_valid;
    if (flush) begin
      fsm_d       = IDLE;
      out_valid_d = 1'b0;
    end else begin
      unique case (fsm_q)
        IDLE: ;
        ROUND: begin
          state_d = round_out;
          if (last_round) begin
            d_out_d     = round_out;
            out_valid_d = 1'b1;
            fsm_d       = DONE;
          end else begin
            rnd_d = rnd_q + RW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_d = 1'b0;
            fsm_d       = IDLE;
          end
        end
        default: fsm_d = IDLE;
      endcase
      // A new block may overlap the output handshake in DONE
      if (accept) begin
        fsm_d   = ROUND;
        state_d = d_in ^ init_rk;
        rnd_d   = RW'(1);
        mode_d  = mode;
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      fsm_q     <= IDLE;
      state_q   <= '0;
      rnd_q     <= '0;
      mode_q    <= 1'b0;
      d_out     <= '0;
      out_valid <= 1'b0;
      started_q <= 1'b0;
    end else begin
      fsm_q     <= fsm_d;
      state_q   <= state_d;
      rnd_q     <= rnd_d;
      mode_q    <= mode_d;
      d_out     <= d_out_d;
      out_valid <= out_valid_d;
      started_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_aes_round_engine.sv
// Directed bench for aes_round_engine: FIPS-197 vectors on NR=10/12/14 builds, backpressure,
// back-to-back streaming, flush and reset aborts.
module tb_aes_round_engine;

  localparam logic [127:0] PT     = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT128  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT192  = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [127:0] CT256  = 128'h8ea2b7ca516745bfeafc49904b496089;

  logic           clk, n_rst, flush;
  logic           mode      [3];
  logic           in_valid  [3];
  logic           in_ready  [3];
  logic [127:0]   d_in      [3];
  logic           out_valid [3];
  logic           out_ready [3];
  logic [127:0]   d_out     [3];
  logic           busy      [3];
  logic [0:43][31:0] ks10;
  logic [0:51][31:0] ks12;
  logic [0:59][31:0] ks14;
  logic [31:0]    w [60];
  int             n_cmp, n_bad;

  aes_round_engine #(.NR(10)) dut10 (
    .clk(clk), .n_rst(n_rst), .flush(flush), .mode(mode[0]), .in_valid(in_valid[0]),
    .in_ready(in_ready[0]), .d_in(d_in[0]), .key_schedule(ks10), .out_valid(out_valid[0]),
    .out_ready(out_ready[0]), .d_out(d_out[0]), .busy(busy[0]));

  aes_round_engine #(.NR(12)) dut12 (
    .clk(clk), .n_rst(n_rst), .flush(flush), .mode(mode[1]), .in_valid(in_valid[1]),
    .in_ready(in_ready[1]), .d_in(d_in[1]), .key_schedule(ks12), .out_valid(out_valid[1]),
    .out_ready(out_ready[1]), .d_out(d_out[1]), .busy(busy[1]));

  aes_round_engine #(.NR(14)) dut14 (
    .clk(clk), .n_rst(n_rst), .flush(flush), .mode(mode[2]), .in_valid(in_valid[2]),
    .in_ready(in_ready[2]), .d_in(d_in[2]), .key_schedule(ks14), .out_valid(out_valid[2]),
    .out_ready(out_ready[2]), .d_out(d_out[2]), .busy(busy[2]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Reference S-box built from the field inverse plus affine map, used only for key expansion
  function automatic logic [7:0] tb_gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa, bb;
    p = 8'h00; aa = a; bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
      bb = {1'b0, bb[7:1]};
    end
    return p;
  endfunction

  function automatic logic [7:0] tb_sbox(input logic [7:0] x);
    logic [7:0] inv;
    inv = 8'h00;
    if (x != 8'h00)
      for (int y = 1; y < 256; y++)
        if (tb_gmul(x, 8'(y)) == 8'h01) inv = 8'(y);
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
               ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] v);
    return {tb_sbox(v[31:24]), tb_sbox(v[23:16]), tb_sbox(v[15:8]), tb_sbox(v[7:0])};
  endfunction

  // Key bytes are 00,01,02,... as in the FIPS-197 appendix examples
  task automatic expand_key(input int nk, input int nr);
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < nk; i++) w[i] = {8'(4*i), 8'(4*i+1), 8'(4*i+2), 8'(4*i+3)};
    for (int i = nk; i < 4*(nr+1); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = tb_gmul(rc, 8'h02);
      end else if (nk > 6 && i % nk == 4) begin
        t = sub_word(t);
      end
      w[i] = w[i-nk] ^ t;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [127:0] observed,
                              input logic [127:0] expected);
    n_cmp++;
    assert (observed === expected) else begin
      n_bad++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic apply_stimulus(input int idx, input logic m, input logic [127:0] din);
    check_output($sformatf("dut%0d in_ready before accept", idx), 128'(in_ready[idx]), 128'(1'b1));
    mode[idx]     = m;
    d_in[idx]     = din;
    in_valid[idx] = 1'b1;
    tick();
    in_valid[idx] = 1'b0;
  endtask

  task automatic wait_out(input int idx, input int budget, output int lat);
    lat = 0;
    while (out_valid[idx] !== 1'b1 && lat < budget) begin
      tick();
      lat++;
    end
  endtask

  task automatic run_block(input int idx, input int nr, input logic m, input logic [127:0] din,
                           input logic [127:0] exp, input string tag);
    int lat;
    apply_stimulus(idx, m, din);
    check_output({tag, " busy after accept"}, 128'(busy[idx]), 128'(1'b1));
    wait_out(idx, nr + 5, lat);
    check_output({tag, " latency"}, 128'(lat), 128'(nr));
    check_output({tag, " d_out"}, d_out[idx], exp);
    out_ready[idx] = 1'b1;
    tick();
    out_ready[idx] = 1'b0;
    check_output({tag, " out_valid after handshake"}, 128'(out_valid[idx]), 128'(1'b0));
    check_output({tag, " busy after handshake"}, 128'(busy[idx]), 128'(1'b0));
  endtask

  initial begin
    int lat, seen;
    n_cmp = 0;
    n_bad = 0;
    flush = 1'b0;
    n_rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      mode[i] = 1'b0; in_valid[i] = 1'b0; d_in[i] = '0; out_ready[i] = 1'b0;
    end
    expand_key(4, 10);
    for (int i = 0; i < 44; i++) ks10[i] = w[i];
    expand_key(6, 12);
    for (int i = 0; i < 52; i++) ks12[i] = w[i];
    expand_key(8, 14);
    for (int i = 0; i < 60; i++) ks14[i] = w[i];

    $display("[TB] reset checks");
    #2 n_rst = 1'b0;
    #1;
    for (int i = 0; i < 3; i++)
      check_output($sformatf("reset in_ready dut%0d", i), 128'(in_ready[i]), 128'(1'b0));
    check_output("reset out_valid", 128'(out_valid[0]), 128'(1'b0));
    check_output("reset d_out", d_out[0], 128'h0);
    check_output("reset busy", 128'(busy[0]), 128'(1'b0));
    tick();
    tick();
    check_output("in_ready held in reset", 128'(in_ready[0]), 128'(1'b0));
    n_rst = 1'b1;
    #1;
    check_output("in_ready before first edge", 128'(in_ready[0]), 128'(1'b0));
    tick();
    for (int i = 0; i < 3; i++)
      check_output($sformatf("in_ready after release dut%0d", i), 128'(in_ready[i]), 128'(1'b1));

    $display("[TB] AES-128 encrypt/decrypt");
    run_block(0, 10, 1'b1, PT, CT128, "aes128 enc");
    run_block(0, 10, 1'b0, CT128, PT, "aes128 dec");

    $display("[TB] backpressure");
    apply_stimulus(0, 1'b1, PT);
    wait_out(0, 15, lat);
    check_output("bp latency", 128'(lat), 128'(10));
    for (int i = 0; i < 5; i++) begin
      check_output($sformatf("bp hold d_out %0d", i), d_out[0], CT128);
      check_output($sformatf("bp hold in_ready %0d", i), 128'(in_ready[0]), 128'(1'b0));
      check_output($sformatf("bp hold out_valid %0d", i), 128'(out_valid[0]), 128'(1'b1));
      tick();
    end
    out_ready[0] = 1'b1;
    in_valid[0]  = 1'b1;
    mode[0]      = 1'b0;
    d_in[0]      = CT128;
    #1;
    check_output("bp in_ready with out_ready", 128'(in_ready[0]), 128'(1'b1));
    tick();
    in_valid[0]  = 1'b0;
    out_ready[0] = 1'b0;
    check_output("bp out_valid after overlap", 128'(out_valid[0]), 128'(1'b0));
    check_output("bp busy after overlap", 128'(busy[0]), 128'(1'b1));
    wait_out(0, 15, lat);
    check_output("bp second latency", 128'(lat), 128'(10));
    check_output("bp second d_out", d_out[0], PT);
    out_ready[0] = 1'b1;
    tick();
    out_ready[0] = 1'b0;
    check_output("bp final out_valid", 128'(out_valid[0]), 128'(1'b0));

    $display("[TB] back-to-back stream");
    mode[0]      = 1'b1;
    d_in[0]      = PT;
    in_valid[0]  = 1'b1;
    out_ready[0] = 1'b1;
    tick();
    for (int k = 0; k < 4; k++) begin
      if (k > 0) begin
        tick();
        check_output($sformatf("stream blk%0d out_valid drop", k), 128'(out_valid[0]), 128'(1'b0));
      end
      if (k < 3) begin
        mode[0] = ((k + 1) % 2 == 0);
        d_in[0] = ((k + 1) % 2 == 0) ? PT : CT128;
      end else begin
        in_valid[0] = 1'b0;
      end
      wait_out(0, 15, lat);
      check_output($sformatf("stream blk%0d latency", k), 128'(lat), 128'(10));
      check_output($sformatf("stream blk%0d d_out", k), d_out[0], (k % 2 == 0) ? CT128 : PT);
    end
    tick();
    out_ready[0] = 1'b0;
    check_output("stream end out_valid", 128'(out_valid[0]), 128'(1'b0));
    check_output("stream end busy", 128'(busy[0]), 128'(1'b0));

    $display("[TB] flush abort");
    apply_stimulus(0, 1'b1, PT);
    for (int i = 0; i < 4; i++) tick();
    check_output("flush busy before", 128'(busy[0]), 128'(1'b1));
    flush       = 1'b1;
    in_valid[0] = 1'b1;
    mode[0]     = 1'b1;
    d_in[0]     = PT;
    tick();
    flush       = 1'b0;
    in_valid[0] = 1'b0;
    check_output("flush busy", 128'(busy[0]), 128'(1'b0));
    check_output("flush out_valid", 128'(out_valid[0]), 128'(1'b0));
    check_output("flush d_out retained", d_out[0], PT);
    check_output("flush in_ready", 128'(in_ready[0]), 128'(1'b1));
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (out_valid[0] === 1'b1) seen++;
    end
    check_output("flush no out_valid", 128'(seen), 128'(0));

    $display("[TB] reset abort");
    apply_stimulus(0, 1'b0, CT128);
    for (int i = 0; i < 3; i++) tick();
    n_rst = 1'b0;
    #1;
    check_output("rst abort in_ready", 128'(in_ready[0]), 128'(1'b0));
    check_output("rst abort out_valid", 128'(out_valid[0]), 128'(1'b0));
    check_output("rst abort d_out", d_out[0], 128'h0);
    check_output("rst abort busy", 128'(busy[0]), 128'(1'b0));
    tick();
    n_rst = 1'b1;
    #1;
    check_output("rst abort in_ready pre-edge", 128'(in_ready[0]), 128'(1'b0));
    tick();
    check_output("rst abort in_ready post-edge", 128'(in_ready[0]), 128'(1'b1));
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (out_valid[0] === 1'b1) seen++;
    end
    check_output("rst abort no out_valid", 128'(seen), 128'(0));
    run_block(0, 10, 1'b1, PT, CT128, "after abort enc");

    $display("[TB] AES-192 and AES-256");
    run_block(1, 12, 1'b1, PT, CT192, "aes192 enc");
    run_block(1, 12, 1'b0, CT192, PT, "aes192 dec");
    run_block(2, 14, 1'b1, PT, CT256, "aes256 enc");
    run_block(2, 14, 1'b0, CT256, PT, "aes256 dec");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
